// File: rtl/riscv_imm_pkg.sv
// Shared constants for the RV32I immediate encoder: format codes, field masks and the
// representable ranges used when IMM_RANGE_CHECK_EN is defined.
package riscv_imm_pkg;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;

  localparam logic [31:0] MASK_I = 32'hFFF0_0000;
  localparam logic [31:0] MASK_S = 32'hFE00_0F80;
  localparam logic [31:0] MASK_B = 32'hFE00_0F80;
  localparam logic [31:0] MASK_U = 32'hFFFF_F000;
  localparam logic [31:0] MASK_J = 32'hFFFF_F000;

  // B and J offsets are halfword multiples, hence the even upper bounds.
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [31:0] base;
  } enc_req_t;

  function automatic logic [31:0] fmt_mask(input logic [2:0] fmt);
    case (fmt)
      FMT_I:   return MASK_I;
      FMT_S:   return MASK_S;
      FMT_B:   return MASK_B;
      FMT_U:   return MASK_U;
      FMT_J:   return MASK_J;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Streaming bus of the immediate encoder: assembler-side input handshake and
// imem-writer-side output handshake. The encoder uses the slave modport.
interface imm_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [31:0]       in_imm;
  logic [31:0]       in_base;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport slave (
    input  in_valid, in_fmt, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport master (
    output in_valid, in_fmt, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/imm_enc_core.sv
// Combinational packer: places an immediate into the RV32I format fields of a base word.
// Macro IMM_RANGE_CHECK_EN adds a representability check on the immediate.
module imm_enc_core
  import riscv_imm_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output logic [31:0] instr,
  output logic        err
);

  logic [31:0] placed;
  logic [31:0] mask;
  logic        fmt_bad;
  logic        range_bad;

  always_comb begin
    placed    = 32'h0000_0000;
    mask      = fmt_mask(fmt);
    fmt_bad   = 1'b0;
    range_bad = 1'b0;

    case (fmt)
      FMT_I:   placed = {imm[11:0], 20'b0};
      FMT_S:   placed = {imm[11:5], 13'b0, imm[4:0], 7'b0};
      FMT_B:   placed = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
      FMT_U:   placed = {imm[31:12], 12'b0};
      FMT_J:   placed = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
      default: fmt_bad = 1'b1;
    endcase

`ifdef IMM_RANGE_CHECK_EN
    // The word is still emitted with a truncated field; only the flag reports it.
    case (fmt)
      FMT_I, FMT_S: range_bad = ($signed(imm) < IMM12_MIN) || ($signed(imm) > IMM12_MAX);
      FMT_B:        range_bad = ($signed(imm) < IMM13_MIN) || ($signed(imm) > IMM13_MAX) || imm[0];
      FMT_U:        range_bad = (imm[11:0] != 12'h000);
      FMT_J:        range_bad = ($signed(imm) < IMM21_MIN) || ($signed(imm) > IMM21_MAX) || imm[0];
      default:      range_bad = 1'b0;
    endcase
`endif

    instr = (base & ~mask) | (placed & mask);
    err   = fmt_bad | range_bad;
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder feeding imem writes with a sequential word address.
// Optional macro IMM_RANGE_CHECK_EN (in imm_enc_core) flags non-representable immediates.
module imm_encoder
  import riscv_imm_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  imm_encoder_if.slave bus,
  output logic         err_seen
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic              s1_v_q, s1_v_d;
  enc_req_t          s1_req_q, s1_req_d;
  logic              s2_v_q, s2_v_d;
  logic [31:0]       s2_instr_q, s2_instr_d;
  logic              s2_err_q, s2_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_seen_q, err_seen_d;

  logic              s1_adv;
  logic              s2_adv;
  logic              out_fire;
  logic [31:0]       enc_instr;
  logic              enc_err;

  imm_enc_core u_core (
    .fmt   (s1_req_q.fmt),
    .imm   (s1_req_q.imm),
    .base  (s1_req_q.base),
    .instr (enc_instr),
    .err   (enc_err)
  );

  // Each stage moves when it is empty or the stage after it is moving.
  always_comb begin
    s2_adv     = !s2_v_q || bus.out_ready;
    s1_adv     = !s1_v_q || s2_adv;
    out_fire   = s2_v_q && bus.out_ready;

    s1_v_d     = s1_v_q;
    s1_req_d   = s1_req_q;
    s2_v_d     = s2_v_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    addr_d     = addr_q;
    err_seen_d = err_seen_q;

    if (s1_adv) begin
      s1_v_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_req_d = '{fmt: bus.in_fmt, imm: bus.in_imm, base: bus.in_base};
      end
    end

    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_instr_d = enc_instr;
        s2_err_d   = enc_err;
      end
    end

    if (out_fire) begin
      addr_d     = addr_q + ADDR_W'(1);
      err_seen_d = err_seen_q | s2_err_q;
    end

    // A clear in the handshake cycle still lets that word use the current address.
    if (clr) begin
      addr_d     = BASE;
      err_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_req_q   <= '0;
      s2_v_q     <= 1'b0;
      s2_instr_q <= 32'h0000_0000;
      s2_err_q   <= 1'b0;
      addr_q     <= BASE;
      err_seen_q <= 1'b0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_req_q   <= s1_req_d;
      s2_v_q     <= s2_v_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
      addr_q     <= addr_d;
      err_seen_q <= err_seen_d;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_v_q;
  assign bus.out_instr = s2_instr_q;
  assign bus.out_err   = s2_err_q;
  assign bus.out_addr  = addr_q;
  assign err_seen      = err_seen_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized bench for imm_encoder against a bit-placement-table reference model;
// honours IMM_RANGE_CHECK_EN when that macro is defined for the build.
module tb_imm_encoder;
  import riscv_imm_pkg::*;

  localparam int ADDR_W = 10;
  localparam int WRAP_W = 2;

`ifdef IMM_RANGE_CHECK_EN
  localparam logic RANGE_ON = 1'b1;
`else
  localparam logic RANGE_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic clr2;
  logic err_seen;
  logic err_seen2;

  imm_encoder_if #(.ADDR_W(ADDR_W)) bus ();
  imm_encoder_if #(.ADDR_W(WRAP_W)) bus2 ();

  imm_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .bus      (bus),
    .err_seen (err_seen)
  );

  imm_encoder #(.ADDR_W(WRAP_W), .BASE_ADDR(0)) dut_wrap (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr2),
    .bus      (bus2),
    .err_seen (err_seen2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  int rdy_mode = 1;
  int src_tab [5][32];
  exp_t sb [$];
  logic [ADDR_W-1:0] m_addr = '0;
  logic m_err_seen = 1'b0;
  int bnd [17] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                   -1048576, -1048577, 1048574, 1048575, 1048576, 0, 1, -1};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction bit b takes imm[src_tab[fmt][b]], or keeps the base bit when the entry is -1.
  task automatic buildTable();
    for (int f = 0; f < 5; f++)
      for (int b = 0; b < 32; b++) src_tab[f][b] = -1;
    for (int b = 20; b < 32; b++) src_tab[0][b] = b - 20;
    for (int b = 25; b < 32; b++) src_tab[1][b] = b - 20;
    for (int b = 7;  b < 12; b++) src_tab[1][b] = b - 7;
    src_tab[2][31] = 12;
    for (int b = 25; b < 31; b++) src_tab[2][b] = b - 20;
    for (int b = 8;  b < 12; b++) src_tab[2][b] = b - 7;
    src_tab[2][7] = 11;
    for (int b = 12; b < 32; b++) src_tab[3][b] = b;
    src_tab[4][31] = 20;
    for (int b = 21; b < 31; b++) src_tab[4][b] = b - 20;
    src_tab[4][20] = 11;
    for (int b = 12; b < 20; b++) src_tab[4][b] = b;
  endtask

  function automatic logic [31:0] model_instr(input logic [2:0] fmt, input logic [31:0] imm,
                                              input logic [31:0] base);
    logic [31:0] r;
    r = base;
    if (fmt <= 3'd4)
      for (int b = 0; b < 32; b++)
        if (src_tab[int'(fmt)][b] >= 0) r[b] = imm[src_tab[int'(fmt)][b]];
    return r;
  endfunction

  function automatic logic model_err(input logic [2:0] fmt, input logic [31:0] imm);
    if (fmt > 3'd4) return 1'b1;
`ifdef IMM_RANGE_CHECK_EN
    begin
      longint v;
      v = longint'($signed(imm));
      case (fmt)
        3'd0, 3'd1: return (v < -2048) || (v > 2047);
        3'd2:       return (v < -4096) || (v > 4094) || (v % 2 != 0);
        3'd3:       return (imm % 4096) != 0;
        default:    return (v < -1048576) || (v > 1048574) || (v % 2 != 0);
      endcase
    end
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] rand_imm();
    case ($urandom % 4)
      0:       return 32'($urandom_range(0, 8191)) - 32'd4096;
      1:       return 32'(bnd[$urandom % 17]);
      2:       return $urandom;
      default: return 32'($urandom_range(0, 2097151)) - 32'd1048576;
    endcase
  endfunction

  // Drives one word from a posedge+1 slot and holds it until the encoder takes it.
  task automatic applyStimulus(input logic [2:0] fmt, input logic [31:0] imm, input logic [31:0] base);
    logic acc;
    acc = 1'b0;
    bus.in_fmt   = fmt;
    bus.in_imm   = imm;
    bus.in_base  = base;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    checkOutput("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.out_ready = 1'($urandom % 2);
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Compare process: every non-reset cycle, checked at the falling edge.
  initial begin : monitor
    logic fire;
    exp_t e;
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst) begin
        fire = bus.out_valid && bus.out_ready;
        checkOutput("err_seen", 32'(err_seen), 32'(m_err_seen));
        checkOutput("in_ready", 32'(bus.in_ready), 32'((sb.size() < 2) || bus.out_ready));
        if (fire) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL spurious_out: out_valid=1 with 0 words in flight, required 0");
          end else begin
            e = sb.pop_front();
            checkOutput("out_instr", bus.out_instr, e.instr);
            checkOutput("out_err", 32'(bus.out_err), 32'(e.err));
            checkOutput("out_addr", 32'(bus.out_addr), 32'(m_addr));
            if (e.err) m_err_seen = 1'b1;
            n_out++;
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          x.instr = model_instr(bus.in_fmt, bus.in_imm, bus.in_base);
          x.err   = model_err(bus.in_fmt, bus.in_imm);
          sb.push_back(x);
        end
        if (clr) begin
          m_addr     = '0;
          m_err_seen = 1'b0;
        end else if (fire) begin
          m_addr = m_addr + 1'b1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main
    int got;
    int sent;
    int base_out;
    logic [WRAP_W-1:0] wrap_addr [5];

    buildTable();
    rst = 1'b1;
    clr = 1'b0;
    clr2 = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_fmt = 3'd0;
    bus.in_imm = 32'd0;
    bus.in_base = 32'd0;
    bus2.in_valid = 1'b0;
    bus2.in_fmt = 3'd0;
    bus2.in_imm = 32'd0;
    bus2.in_base = 32'h0000_0013;
    bus2.out_ready = 1'b1;

    checkOutput("pin_I", model_instr(3'd0, 32'hFFFF_FFFF, 32'h0000_0013), 32'hFFF0_0013);
    checkOutput("pin_S", model_instr(3'd1, 32'd8, 32'h0000_2023), 32'h0000_2423);
    checkOutput("pin_B", model_instr(3'd2, 32'hFFFF_FFFC, 32'h0000_0063), 32'hFE00_0EE3);
    checkOutput("pin_J", model_instr(3'd4, 32'd2048, 32'h0000_006F), 32'h0010_006F);
    checkOutput("pin_U", model_instr(3'd3, 32'h1234_5000, 32'h0000_0037), 32'h1234_5037);
    checkOutput("pin_bad_fmt", model_instr(3'd7, 32'hFFFF_FFFF, 32'h1234_5678), 32'h1234_5678);
    checkOutput("pin_err_B_odd", 32'(model_err(3'd2, 32'd3)), 32'(RANGE_ON));
    checkOutput("pin_err_fmt7", 32'(model_err(3'd7, 32'd0)), 32'd1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_instr", bus.out_instr, 32'd0);
    checkOutput("rst_out_err", 32'(bus.out_err), 32'd0);
    checkOutput("rst_err_seen", 32'(err_seen), 32'd0);
    checkOutput("rst_out_addr", 32'(bus.out_addr), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    $display("[TB] latency and directed vectors");
    bus.in_fmt = 3'd0;
    bus.in_imm = 32'hFFFF_FFFF;
    bus.in_base = 32'h0000_0013;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkOutput("lat_cycle1_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_cycle2_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("lat_I_instr", bus.out_instr, 32'hFFF0_0013);
    checkOutput("lat_I_addr", 32'(bus.out_addr), 32'd0);
    applyStimulus(3'd1, 32'd8, 32'h0000_2023);
    applyStimulus(3'd2, 32'hFFFF_FFFC, 32'h0000_0063);
    applyStimulus(3'd4, 32'd2048, 32'h0000_006F);
    applyStimulus(3'd3, 32'h1234_5000, 32'h0000_0037);
    drain();
    checkOutput("directed_addr", 32'(bus.out_addr), 32'd5);

    $display("[TB] error flags and clear");
    applyStimulus(3'd2, 32'd3, 32'h0000_0063);
    applyStimulus(3'd7, 32'hDEAD_BEEF, 32'h1234_5678);
    drain();
    checkOutput("err_seen_sticky", 32'(err_seen), 32'd1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    checkOutput("clr_err_seen", 32'(err_seen), 32'd0);
    checkOutput("clr_addr", 32'(bus.out_addr), 32'd0);

    $display("[TB] backpressure burst");
    rdy_mode = 0;
    base_out = n_out;
    for (int i = 0; i < 8; i++) applyStimulus(3'($urandom % 5), rand_imm(), $urandom);
    drain();
    checkOutput("burst_count", 32'(n_out - base_out), 32'd8);
    checkOutput("burst_addr", 32'(bus.out_addr), 32'd8);

    $display("[TB] random stream");
    for (int i = 0; i < 400; i++) begin
      logic [2:0] f;
      logic [31:0] v;
      f = ($urandom % 10 < 8) ? 3'($urandom % 5) : 3'(5 + $urandom % 3);
      v = rand_imm();
      if (f == 3'd3 && ($urandom % 2 == 0)) v = v & 32'hFFFF_F000;
      applyStimulus(f, v, $urandom);
      if ($urandom % 40 == 0) begin
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
      end else if ($urandom % 4 == 0) begin
        idle(1);
      end
    end
    drain();

    $display("[TB] address wrap on ADDR_W=2 instance");
    got = 0;
    sent = 0;
    bus2.in_valid = 1'b1;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      if (bus2.out_valid && bus2.out_ready) begin
        wrap_addr[got] = bus2.out_addr;
        got++;
      end
      if (bus2.in_valid && bus2.in_ready) sent++;
      @(posedge clk);
      #1;
      if (sent >= 5) bus2.in_valid = 1'b0;
    end
    bus2.in_valid = 1'b0;
    checkOutput("wrap_count", 32'(got), 32'd5);
    for (int i = 0; i < got; i++) checkOutput("wrap_addr", 32'(wrap_addr[i]), 32'(i % 4));

    $display("[TB] reset mid-stream");
    rdy_mode = 2;
    idle(1);
    applyStimulus(3'd0, 32'd5, 32'h0000_0013);
    applyStimulus(3'd1, 32'd6, 32'h0000_2023);
    checkOutput("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_async_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_async_addr", 32'(bus.out_addr), 32'd0);
    idle(2);
    sb.delete();
    m_addr = '0;
    m_err_seen = 1'b0;
    rdy_mode = 1;
    rst = 1'b0;
    idle(2);
    checkOutput("post_rst_valid", 32'(bus.out_valid), 32'd0);
    applyStimulus(3'd4, 32'hFFFF_FFFE, 32'h0000_006F);
    drain();
    checkOutput("post_rst_addr", 32'(bus.out_addr), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
